// File: rtl/btn_events_if.sv
// Button/key-event bundle between the front-panel debouncers, the event
// generator and the calculator input decoder.
interface btn_events_if #(
  parameter int N_BTN = 5
);
  localparam int KW = $clog2(N_BTN);

  logic [N_BTN-1:0] i_btn;
  logic             o_press;
  logic [KW-1:0]    o_code;
  logic             o_repeat;
  logic             o_held;

  // Source of button levels, consumer of key events
  modport master (
    output i_btn,
    input  o_press,
    input  o_code,
    input  o_repeat,
    input  o_held
  );

  // Event generator side
  modport slave (
    input  i_btn,
    output o_press,
    output o_code,
    output o_repeat,
    output o_held
  );
endinterface

// File: rtl/btn_events.sv
// Turns debounced button levels into one-cycle key-press events with
// typematic auto-repeat while the latched key stays held.
module btn_events #(
  parameter int N_BTN         = 5,
  parameter int CW            = 26,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  btn_events_if.slave  bus
);
  localparam int KW = $clog2(N_BTN);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] prev;
  logic [N_BTN-1:0] rise;
  logic [KW-1:0]    key, key_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             press_q, press_nxt;
  logic             repeat_q, repeat_nxt;
  logic             held_q, held_nxt;
  logic             picked;

  // State, counter, latched key, edge history and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      prev     <= '1;
      key      <= '0;
      cnt      <= '0;
      press_q  <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= bus.i_btn;
      key      <= key_nxt;
      cnt      <= cnt_nxt;
      press_q  <= press_nxt;
      repeat_q <= repeat_nxt;
      held_q   <= held_nxt;
    end
  end

  // Edge detection, key selection and hold/repeat sequencing
  always_comb begin
    rise       = bus.i_btn & ~prev;
    state_nxt  = state;
    key_nxt    = key;
    cnt_nxt    = cnt;
    press_nxt  = 1'b0;
    repeat_nxt = 1'b0;
    picked     = 1'b0;

    case (state)
      IDLE: begin
        if (rise != '0) begin
          // Lowest index wins; other simultaneous edges are dropped for good
          for (int unsigned i = 0; i < N_BTN; i++) begin
            if (rise[i] && !picked) begin
              picked  = 1'b1;
              key_nxt = KW'(i);
            end
          end
          press_nxt = 1'b1;
          cnt_nxt   = HOLD_LOAD;
          state_nxt = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!bus.i_btn[key]) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          press_nxt  = 1'b1;
          repeat_nxt = 1'b1;
          cnt_nxt    = REPEAT_LOAD;
          state_nxt  = REPEAT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    held_nxt = (state_nxt != IDLE);
  end

  assign bus.o_press  = press_q;
  assign bus.o_code   = key;
  assign bus.o_repeat = repeat_q;
  assign bus.o_held   = held_q;
endmodule

// File: tb/tb_btn_events.sv
// Self-checking bench for btn_events with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_events;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btn_events_if #(.N_BTN(5)) bus ();

  btn_events #(
    .N_BTN(5),
    .CW(8),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] btn;
    logic       press;
    logic [2:0] code;
    logic       rep;
    logic       held;
  } vec_t;

  vec_t vec [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic p, input logic [2:0] c,
                           input logic r, input logic h);
    check({name, ".press"},  32'(bus.o_press),  32'(p));
    check({name, ".code"},   32'(bus.o_code),   32'(c));
    check({name, ".repeat"}, 32'(bus.o_repeat), 32'(r));
    check({name, ".held"},   32'(bus.o_held),   32'(h));
  endtask

  initial begin
    bus.i_btn = '0;
    //            rst   btn       press code  rep   held
    vec[0]  = '{1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0}; // reset
    vec[1]  = '{1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 5'b00100, 1'b1, 3'd2, 1'b0, 1'b1}; // tap bit 2
    vec[4]  = '{1'b0, 5'b00100, 1'b0, 3'd2, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 5'b00100, 1'b0, 3'd2, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 5'b10110, 1'b1, 3'd1, 1'b0, 1'b1}; // simultaneous
    vec[9]  = '{1'b0, 5'b10110, 1'b0, 3'd1, 1'b0, 1'b1};
    vec[10] = '{1'b0, 5'b10100, 1'b0, 3'd1, 1'b0, 1'b0}; // release key 1
    vec[11] = '{1'b0, 5'b10100, 1'b0, 3'd1, 1'b0, 1'b0};
    vec[12] = '{1'b0, 5'b00100, 1'b0, 3'd1, 1'b0, 1'b0}; // release 4
    vec[13] = '{1'b0, 5'b10100, 1'b1, 3'd4, 1'b0, 1'b1}; // re-press 4
    vec[14] = '{1'b0, 5'b10000, 1'b0, 3'd4, 1'b0, 1'b1}; // non-key release
    vec[15] = '{1'b0, 5'b10001, 1'b0, 3'd4, 1'b0, 1'b1}; // edge in DELAY lost
    vec[16] = '{1'b0, 5'b00001, 1'b0, 3'd4, 1'b0, 1'b0}; // key released
    vec[17] = '{1'b0, 5'b00001, 1'b0, 3'd4, 1'b0, 1'b0}; // held, no edge
    vec[18] = '{1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      rst       = vec[i].rst;
      bus.i_btn = vec[i].btn;
      tick();
      check_out($sformatf("vec%0d", i), vec[i].press, vec[i].code, vec[i].rep, vec[i].held);
    end

    // Hold bit 4 for 30 cycles: pulses at 0, 8, 12, ..., 28
    bus.i_btn = 5'b10000;
    for (int i = 0; i < 30; i++) begin
      logic exp_p;
      tick();
      exp_p = (i == 0) || (i >= 8 && (i % 4) == 0);
      check($sformatf("hold.press[%0d]", i), 32'(bus.o_press), 32'(exp_p));
      check($sformatf("hold.held[%0d]", i), 32'(bus.o_held), 32'd1);
      if (exp_p) begin
        check($sformatf("hold.code[%0d]", i), 32'(bus.o_code), 32'd4);
        check($sformatf("hold.repeat[%0d]", i), 32'(bus.o_repeat), 32'(i != 0));
      end
    end
    bus.i_btn = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("hold_rel.press[%0d]", i), 32'(bus.o_press), 32'd0);
      check($sformatf("hold_rel.held[%0d]", i), 32'(bus.o_held), 32'd0);
    end

    // Release bit 0 exactly when the hold count expires
    bus.i_btn = 5'b00001;
    tick();
    check_out("race.first", 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("race.press[%0d]", i), 32'(bus.o_press), 32'd0);
    end
    bus.i_btn = '0;
    tick();
    check_out("race.expiry", 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("race.after[%0d]", i), 32'(bus.o_press), 32'd0);
    end

    // Bit 3 held through reset deassertion must not fire
    bus.i_btn = 5'b01000;
    rst = 1'b1;
    tick();
    tick();
    check_out("rst.in", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst.held_thru.press[%0d]", i), 32'(bus.o_press), 32'd0);
      check($sformatf("rst.held_thru.held[%0d]", i), 32'(bus.o_held), 32'd0);
    end
    bus.i_btn = '0;
    tick();
    bus.i_btn = 5'b01000;
    tick();
    check_out("rst.repress", 1'b1, 3'd3, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) begin
      tick();
      check($sformatf("rst.run.press[%0d]", i), 32'(bus.o_press), 32'(i == 8));
    end

    // Reset during REPEAT cancels everything
    rst = 1'b1;
    tick();
    check_out("rst.mid", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rst.post.press[%0d]", i), 32'(bus.o_press), 32'd0);
      check($sformatf("rst.post.held[%0d]", i), 32'(bus.o_held), 32'd0);
    end
    bus.i_btn = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_events.md
# btn_events

Converts the debounced button levels of the calculator front panel into discrete key-press events with typematic auto-repeat. It sits directly downstream of the per-button debouncers and upstream of the calculator input decoder. It emits a one-cycle `o_press` pulse carrying the index of the pressed button. While that button stays held, it emits further pulses after an initial hold delay and then at a fixed repeat rate.

## Interface
- `N_BTN`, 5: number of buttons; must be ≥ 2.
- `CW`, 26: width of the hold/repeat counter.
- `HOLD_CYCLES`, 50_000_000: cycles from the first press pulse to the first repeat pulse; must be in the range 2 … 2^CW.
- `REPEAT_CYCLES`, 10_000_000: cycles between consecutive repeat pulses; must be in the range 2 … 2^CW.

- `i_clk`, input, 1: system clock; the only clock.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_btn`, input, N_BTN: debounced button levels, 1 = pressed. Already synchronous to `i_clk`.
- `o_press`, output, 1: one-cycle key event pulse.
- `o_code`, output, $clog2(N_BTN): index of the latched key. Valid when `o_press` = 1; holds its value until the next new press.
- `o_repeat`, output, 1: qualifies `o_press`. 1 = auto-repeat event, 0 = initial press.
- `o_held`, output, 1: high while a latched key is being tracked (state DELAY or REPEAT).

## Operation
- Internal registers:
  - `prev[N_BTN-1:0]`: previous-cycle copy of `i_btn`.
  - `rise = i_btn & ~prev`: combinational rising-edge vector.
  - `key`: index of the latched button.
  - `cnt[CW-1:0]`: hold/repeat counter.
- `prev` is updated from `i_btn` every cycle, in every state.
- States:
  - IDLE
    - If `rise` ≠ 0: latch `key` = lowest set index of `rise`. Pulse `o_press` with `o_repeat` = 0. Load `cnt` = HOLD_CYCLES-1. Go to DELAY.
    - If `rise` = 0: stay in IDLE.
  - DELAY
    - If `i_btn[key]` = 0: go to IDLE, no pulse.
    - Else if `cnt` = 0: pulse `o_press` with `o_repeat` = 1. Load `cnt` = REPEAT_CYCLES-1. Go to REPEAT.
    - Else: decrement `cnt`.
  - REPEAT
    - If `i_btn[key]` = 0: go to IDLE, no pulse.
    - Else if `cnt` = 0: pulse `o_press` with `o_repeat` = 1. Reload `cnt` = REPEAT_CYCLES-1. Stay in REPEAT.
    - Else: decrement `cnt`.
- Boundary rules:
  - Simultaneous rising edges in IDLE: the lowest index wins. The other edges are discarded. Those buttons do not fire later, even if still held, until they are released and pressed again.
  - Edges on other buttons while in DELAY or REPEAT are ignored and lost.
  - On return to IDLE, still-held buttons have no edge and do not fire.
  - Release of `key` in the same cycle that `cnt` reaches 0: release wins, no pulse.
  - Rising edges in the cycle where the state machine leaves DELAY or REPEAT for IDLE are ignored.
  - Release of a non-latched button never affects tracking.
  - `cnt` never wraps. It is only decremented when nonzero.

## Timing
- Reset values:
  - state = IDLE
  - `prev` = all ones, so buttons held through reset are ignored until released and pressed again
  - `cnt` = 0, `key` = 0
  - `o_press` = 0, `o_repeat` = 0, `o_code` = 0, `o_held` = 0
- All outputs are registered.
- Latency:
  - `i_btn[k]` is first sampled high at clock edge t (with `prev[k]` = 0).
  - `o_press`, `o_code` = k and `o_held` are all high/valid after edge t.
  - `o_press` stays high for exactly 1 cycle.
- Pulse spacing while held:
  - first repeat pulse occurs HOLD_CYCLES cycles after the initial pulse;
  - each later pulse occurs REPEAT_CYCLES cycles after the previous one.
- `o_held` drops one cycle after `i_btn[key]` is first sampled low.
- Reset asserted mid-operation:
  - takes effect on the next edge;
  - pending repeats are cancelled;
  - outputs go to their reset values the cycle after reset is sampled.
- Throughput: at most one `o_press` per cycle, and never on two consecutive cycles (spacing ≥ 2).

## Test plan
Test parameters for all scenarios: N_BTN=5, HOLD_CYCLES=8, REPEAT_CYCLES=4.

1. **Tap:** press `i_btn[2]` for 3 cycles, then release.
   - Required: exactly one `o_press` with `o_code` = 2, `o_repeat` = 0.
   - Required: `o_held` high for 3 cycles; no repeat pulses.
2. **Hold:** hold `i_btn[4]` for 30 cycles.
   - Required: pulses at relative cycles 0 (`o_repeat` = 0), then 8, 12, 16, 20, 24, 28 (`o_repeat` = 1), all with `o_code` = 4.
   - Required: no pulse after release.
3. **Simultaneous press:** `i_btn` rises from 0 to 5'b10110 in a single cycle.
   - Required: one pulse with `o_code` = 1.
   - Then release bit 1 while bits 2 and 4 stay held: no further pulses.
   - Then release and re-press bit 4: pulse with `o_code` = 4.
4. **Release/expiry race:** hold bit 0 and release it in the exact cycle `cnt` = 0 in DELAY.
   - Required: no repeat pulse; state returns to IDLE.
5. **Reset:**
   - Hold bit 3 across the deassertion of `i_rst`: no pulse. Release and re-press: pulse with `o_code` = 3.
   - Assert `i_rst` during REPEAT: `o_press`, `o_held` and `o_code` read 0 on the following cycle, with no further pulses.
